// File: rtl/mips_pkg.sv
// Shared definitions for the 16-bit simplified MIPS datapath.
// Datapath widths, ALU op encodings ({ainvert, binvert, sel[1:0]}),
// the decoded control-bit bundle, and a register-index match helper.
package mips_pkg;

   localparam int WIDTH  = 16;
   localparam int REG_AW = 2;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // Decoded control bits carried from ID into EX.
   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic branch;
      logic alusrc;
   } ctrl_t;

   // r0 is hard-wired to zero, so it never matches as a dependency.
   function automatic logic idx_match(input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b);
      return (a != '0) && (a == b);
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// One-operand forwarding select. The younger EX/MEM result beats the
// older MEM/WB result; with no match the registered operand is used.
module fwd_mux
   import mips_pkg::*;
(
   input  logic [REG_AW-1:0] idx_i,
   input  logic [WIDTH-1:0]  reg_data_i,
   input  logic              exmem_we_i,
   input  logic [REG_AW-1:0] exmem_rd_i,
   input  logic [WIDTH-1:0]  exmem_data_i,
   input  logic              memwb_we_i,
   input  logic [REG_AW-1:0] memwb_rd_i,
   input  logic [WIDTH-1:0]  memwb_data_i,
   output logic [WIDTH-1:0]  data_o
);

   // Priority select: EX/MEM, then MEM/WB, then the registered value.
   always_comb begin
      data_o = reg_data_i;
      if (exmem_we_i && idx_match(exmem_rd_i, idx_i)) begin
         data_o = exmem_data_i;
      end else if (memwb_we_i && idx_match(memwb_rd_i, idx_i)) begin
         data_o = memwb_data_i;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard stall.
// Build option ID_EX_FORWARD_EN: when defined, EX operands are forwarded
// from EX/MEM and MEM/WB and only load-use stalls. When undefined, the
// forwarding sources are tied off and any RAW against EX or EX/MEM stalls;
// the MEM/WB write-back bypass at capture is present in both builds.
module id_ex_stage
   import mips_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [WIDTH-1:0]  id_rs_data,
   input  logic [WIDTH-1:0]  id_rt_data,
   input  logic [WIDTH-1:0]  id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [3:0]        id_alu_op,
   input  logic              id_alusrc,
   input  logic              id_regdst,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_memtoreg,
   input  logic              id_branch,
   input  logic              flush,
   input  logic              exmem_regwrite,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [WIDTH-1:0]  exmem_result,
   input  logic              memwb_regwrite,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [WIDTH-1:0]  memwb_result,
   output logic              stall,
   output logic              ex_valid,
   output logic [3:0]        ex_alu_op,
   output logic [WIDTH-1:0]  ex_a,
   output logic [WIDTH-1:0]  ex_b,
   output logic [WIDTH-1:0]  ex_store_data,
   output logic [REG_AW-1:0] ex_wreg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_memtoreg,
   output logic              ex_branch
);

   logic              valid_q, valid_d;
   ctrl_t             ctrl_q, ctrl_d, id_ctrl;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, wreg_q, wreg_d;
   logic [WIDTH-1:0]  rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
   logic [WIDTH-1:0]  rs_cap, rt_cap, fwd_rs, fwd_rt;
   logic              uses_rt, hazard, dep_ex, dep_exmem;
   logic              fwd_exmem_en, fwd_memwb_en;

   assign id_ctrl = '{regwrite: id_regwrite, memread: id_memread,
                      memwrite: id_memwrite, memtoreg: id_memtoreg,
                      branch: id_branch, alusrc: id_alusrc};

   assign uses_rt = ~id_alusrc | id_memwrite | id_branch;

   // Register-file write in progress this cycle is not yet visible in the
   // read data, so take it straight from MEM/WB while capturing.
   assign rs_cap = (memwb_regwrite && idx_match(memwb_rd, id_rs)) ? memwb_result : id_rs_data;
   assign rt_cap = (memwb_regwrite && idx_match(memwb_rd, id_rt)) ? memwb_result : id_rt_data;

   // Does the ID instruction read the register written by EX / EX/MEM?
   assign dep_ex    = idx_match(wreg_q, id_rs) || (uses_rt && idx_match(wreg_q, id_rt));
   assign dep_exmem = idx_match(exmem_rd, id_rs) || (uses_rt && idx_match(exmem_rd, id_rt));

`ifdef ID_EX_FORWARD_EN
   assign hazard       = valid_q && ctrl_q.memread && dep_ex;
   assign fwd_exmem_en = exmem_regwrite;
   assign fwd_memwb_en = memwb_regwrite;
`else
   assign hazard       = (valid_q && ctrl_q.regwrite && dep_ex) ||
                         (exmem_regwrite && dep_exmem);
   assign fwd_exmem_en = 1'b0;
   assign fwd_memwb_en = 1'b0;
`endif

   assign stall = id_valid && hazard && !flush;

   // Next EX contents: a bubble on flush or stall, else the ID instruction.
   always_comb begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      alu_op_d  = '0;
      rs_d      = '0;
      rt_d      = '0;
      wreg_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      if (!flush && !stall) begin
         valid_d   = id_valid;
         ctrl_d    = id_valid ? id_ctrl : '0;
         alu_op_d  = id_valid ? id_alu_op : '0;
         rs_d      = id_rs;
         rt_d      = id_rt;
         wreg_d    = id_regdst ? id_rd : id_rt;
         rs_data_d = rs_cap;
         rt_data_d = rt_cap;
         imm_d     = id_imm;
      end
   end

   // Pipeline register; reset loads a bubble.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         alu_op_q  <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         wreg_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         alu_op_q  <= alu_op_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         wreg_q    <= wreg_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
      end
   end

   fwd_mux u_fwd_rs (
      .idx_i        (rs_q),
      .reg_data_i   (rs_data_q),
      .exmem_we_i   (fwd_exmem_en),
      .exmem_rd_i   (exmem_rd),
      .exmem_data_i (exmem_result),
      .memwb_we_i   (fwd_memwb_en),
      .memwb_rd_i   (memwb_rd),
      .memwb_data_i (memwb_result),
      .data_o       (fwd_rs)
   );

   fwd_mux u_fwd_rt (
      .idx_i        (rt_q),
      .reg_data_i   (rt_data_q),
      .exmem_we_i   (fwd_exmem_en),
      .exmem_rd_i   (exmem_rd),
      .exmem_data_i (exmem_result),
      .memwb_we_i   (fwd_memwb_en),
      .memwb_rd_i   (memwb_rd),
      .memwb_data_i (memwb_result),
      .data_o       (fwd_rt)
   );

   assign ex_valid      = valid_q;
   assign ex_alu_op     = alu_op_q;
   assign ex_a          = fwd_rs;
   assign ex_b          = ctrl_q.alusrc ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_wreg       = wreg_q;
   assign ex_regwrite   = ctrl_q.regwrite;
   assign ex_memread    = ctrl_q.memread;
   assign ex_memwrite   = ctrl_q.memwrite;
   assign ex_memtoreg   = ctrl_q.memtoreg;
   assign ex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. Expected EX contents are pushed when an ID
// instruction is driven and popped one cycle later; stall is checked in
// the same cycle. Expectations follow ID_EX_FORWARD_EN if defined.
module tb_id_ex_stage;
   import mips_pkg::*;

`ifdef ID_EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic        rst, flush, valid;
      logic [1:0]  rs, rt, rd;
      logic [15:0] rs_data, rt_data, imm;
      logic [3:0]  op;
      logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch;
      logic        xm_we;
      logic [1:0]  xm_rd;
      logic [15:0] xm_res;
      logic        wb_we;
      logic [1:0]  wb_rd;
      logic [15:0] wb_res;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [3:0]  op;
      logic [15:0] a, b, sd;
      logic [1:0]  wreg;
      logic        rw, mr, mw, mt, br;
   } ex_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, id_valid, flush;
   logic [15:0] id_rs_data, id_rt_data, id_imm;
   logic [1:0]  id_rs, id_rt, id_rd;
   logic [3:0]  id_alu_op;
   logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
   logic        exmem_regwrite, memwb_regwrite;
   logic [1:0]  exmem_rd, memwb_rd;
   logic [15:0] exmem_result, memwb_result;
   logic        stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
   logic [3:0]  ex_alu_op;
   logic [15:0] ex_a, ex_b, ex_store_data;
   logic [1:0]  ex_wreg;

   id_ex_stage dut (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
      .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
      .id_branch(id_branch), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b),
      .ex_store_data(ex_store_data), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
      .ex_branch(ex_branch)
   );

   ex_t obs;
   assign obs = {ex_valid, ex_alu_op, ex_a, ex_b, ex_store_data, ex_wreg,
                 ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch};

   int  n_checks = 0;
   int  n_pass   = 0;
   ex_t sb[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   function automatic stim_t nop();
      stim_t s = '0;
      return s;
   endfunction

   function automatic stim_t rtype(input logic [3:0] op, input logic [1:0] rs, rt, rd,
                                   input logic [15:0] rsd, rtd);
      stim_t s = '0;
      s.valid = 1'b1; s.op = op; s.rs = rs; s.rt = rt; s.rd = rd;
      s.rs_data = rsd; s.rt_data = rtd; s.regdst = 1'b1; s.regwrite = 1'b1;
      return s;
   endfunction

   function automatic stim_t itype(input logic [3:0] op, input logic [1:0] rs, rt,
                                   input logic [15:0] rsd, rtd, imm, input logic ld);
      stim_t s = '0;
      s.valid = 1'b1; s.op = op; s.rs = rs; s.rt = rt;
      s.rs_data = rsd; s.rt_data = rtd; s.imm = imm;
      s.alusrc = 1'b1; s.regwrite = 1'b1; s.memread = ld; s.memtoreg = ld;
      return s;
   endfunction

   function automatic ex_t exi(input logic [3:0] op, input logic [15:0] a, b, sd,
                               input logic [1:0] wreg, input logic ld);
      ex_t e = '0;
      e.valid = 1'b1; e.op = op; e.a = a; e.b = b; e.sd = sd; e.wreg = wreg;
      e.rw = 1'b1; e.mr = ld; e.mt = ld;
      return e;
   endfunction

   task automatic drive(input stim_t s);
      reset = s.rst; flush = s.flush; id_valid = s.valid;
      id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
      id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm; id_alu_op = s.op;
      id_alusrc = s.alusrc; id_regdst = s.regdst; id_regwrite = s.regwrite;
      id_memread = s.memread; id_memwrite = s.memwrite; id_memtoreg = s.memtoreg;
      id_branch = s.branch;
      exmem_regwrite = s.xm_we; exmem_rd = s.xm_rd; exmem_result = s.xm_res;
      memwb_regwrite = s.wb_we; memwb_rd = s.wb_rd; memwb_result = s.wb_res;
   endtask

   // One cycle: drive, push what EX must hold next cycle, sample at negedge.
   task automatic run(input string tag, input stim_t s, input logic exp_stall, input ex_t exp_next);
      ex_t e;
      drive(s);
      sb.push_back(exp_next);
      @(negedge clock);
      chk({tag, ":stall"}, 64'(stall), 64'(exp_stall));
      if (sb.size() > 1) begin
         e = sb.pop_front();
         chk({tag, ":ex"}, 64'(obs), 64'(e));
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      stim_t s;
      // Reset held two cycles with a valid instruction present.
      s = rtype(ALU_ADD, 2'd2, 2'd3, 2'd1, 16'h0005, 16'h0007);
      s.rst = 1'b1;
      drive(s);
      sb.push_back('0);
      @(posedge clock);
      #1;
      run("rst", s, 1'b0, '0);

      // add r1,r2,r3 then EX/MEM forward of r2.
      s = rtype(ALU_ADD, 2'd2, 2'd3, 2'd1, 16'h0005, 16'h0007);
      s.imm = 16'h0009;
      run("add", s, 1'b0, exi(ALU_ADD, FWD ? 16'h1234 : 16'h0005, 16'h0007, 16'h0007, 2'd1, 1'b0));
      s = nop(); s.xm_we = 1'b1; s.xm_rd = 2'd2; s.xm_res = 16'h1234;
      run("exmem_fwd", s, 1'b0, '0);

      // or r3,r1,r2 with write-back bypass on rt, then dual-source match on rs.
      s = rtype(ALU_OR, 2'd1, 2'd2, 2'd3, 16'h0011, 16'h0022);
      s.wb_we = 1'b1; s.wb_rd = 2'd2; s.wb_res = 16'h0BAD;
      run("wb_bypass", s, 1'b0, exi(ALU_OR, FWD ? 16'h00AA : 16'h0011, 16'h0BAD, 16'h0BAD, 2'd3, 1'b0));
      s = nop(); s.xm_we = 1'b1; s.xm_rd = 2'd1; s.xm_res = 16'h00AA;
      s.wb_we = 1'b1; s.wb_rd = 2'd1; s.wb_res = 16'h00BB;
      run("dual_prio", s, 1'b0, '0);

      // and r2,r1,r3; r0 sources must never bypass or forward.
      s = rtype(ALU_AND, 2'd1, 2'd3, 2'd2, 16'h0F0F, 16'h00FF);
      s.wb_we = 1'b1; s.wb_rd = 2'd0; s.wb_res = 16'hDEAD;
      run("r0_nobyp", s, 1'b0, exi(ALU_AND, 16'h0F0F, 16'h00FF, 16'h00FF, 2'd2, 1'b0));
      s = nop(); s.xm_we = 1'b1; s.xm_rd = 2'd0; s.xm_res = 16'h00AA;
      s.wb_we = 1'b1; s.wb_rd = 2'd0; s.wb_res = 16'h00BB;
      run("r0_nofwd", s, 1'b0, '0);

      // addi r3,r1,-2: b is the immediate, store data follows rt forwarding.
      s = itype(ALU_ADD, 2'd1, 2'd3, 16'h0100, 16'h7777, 16'hFFFE, 1'b0);
      run("addi", s, 1'b0, exi(ALU_ADD, 16'h0100, 16'hFFFE, FWD ? 16'h5555 : 16'h7777, 2'd3, 1'b0));
      s = nop(); s.wb_we = 1'b1; s.wb_rd = 2'd3; s.wb_res = 16'h5555;
      run("imm_sel", s, 1'b0, '0);

      // Load-use: lw r2,4(r1) followed by sub r3,r2,r1.
      s = itype(ALU_ADD, 2'd1, 2'd2, 16'h0040, 16'h0000, 16'h0004, 1'b1);
      run("lw", s, 1'b0, exi(ALU_ADD, 16'h0040, 16'h0004, 16'h0000, 2'd2, 1'b1));
      s = rtype(ALU_SUB, 2'd2, 2'd1, 2'd3, 16'h0002, 16'h0040);
      run("lu_stall", s, 1'b1, '0);
`ifdef ID_EX_FORWARD_EN
      s.xm_we = 1'b1; s.xm_rd = 2'd2; s.xm_res = 16'h0044;
      run("lu_release", s, 1'b0, exi(ALU_SUB, 16'h9999, 16'h0040, 16'h0040, 2'd3, 1'b0));
      s = nop(); s.wb_we = 1'b1; s.wb_rd = 2'd2; s.wb_res = 16'h9999;
      run("lu_wbfwd", s, 1'b0, '0);
`else
      s.xm_we = 1'b1; s.xm_rd = 2'd2; s.xm_res = 16'h0044;
      run("lu_stall2", s, 1'b1, '0);
      s = rtype(ALU_SUB, 2'd2, 2'd1, 2'd3, 16'h0002, 16'h0040);
      s.wb_we = 1'b1; s.wb_rd = 2'd2; s.wb_res = 16'h9999;
      run("lu_release", s, 1'b0, exi(ALU_SUB, 16'h9999, 16'h0040, 16'h0040, 2'd3, 1'b0));
      run("lu_sub", nop(), 1'b0, '0);
`endif

      // Flush during a load-use hazard: no stall, bubble loaded.
      s = itype(ALU_ADD, 2'd2, 2'd1, 16'h0010, 16'h0000, 16'h0000, 1'b1);
      run("lw2", s, 1'b0, exi(ALU_ADD, 16'h0010, 16'h0000, 16'h0000, 2'd1, 1'b1));
      s = rtype(ALU_ADD, 2'd1, 2'd1, 2'd3, 16'h0003, 16'h0003);
      s.flush = 1'b1;
      run("flush", s, 1'b0, '0);
      run("flush_bub", nop(), 1'b0, '0);

      // Reset asserted while stalled: bubble, and no stall afterwards.
      s = itype(ALU_ADD, 2'd2, 2'd1, 16'h0010, 16'h0000, 16'h0000, 1'b1);
      run("lw3", s, 1'b0, exi(ALU_ADD, 16'h0010, 16'h0000, 16'h0000, 2'd1, 1'b1));
      s = rtype(ALU_ADD, 2'd1, 2'd1, 2'd3, 16'h0003, 16'h0003);
      s.rst = 1'b1;
      run("rst_stall", s, 1'b1, '0);
      s.rst = 1'b0;
      run("rst_after", s, 1'b0, exi(ALU_ADD, 16'h0003, 16'h0003, 16'h0003, 2'd3, 1'b0));
      run("rst_add", nop(), 1'b0, '0);

      // addi r1,r0,0x21 immediately followed by add r2,r1,r1.
      s = itype(ALU_ADD, 2'd0, 2'd1, 16'h0000, 16'h0001, 16'h0021, 1'b0);
      run("addi_r1", s, 1'b0, exi(ALU_ADD, 16'h0000, 16'h0021, 16'h0001, 2'd1, 1'b0));
      s = rtype(ALU_ADD, 2'd1, 2'd1, 2'd2, 16'h0001, 16'h0001);
`ifdef ID_EX_FORWARD_EN
      run("raw", s, 1'b0, exi(ALU_ADD, 16'h0021, 16'h0021, 16'h0021, 2'd2, 1'b0));
      s = nop(); s.xm_we = 1'b1; s.xm_rd = 2'd1; s.xm_res = 16'h0021;
      run("raw_fwd", s, 1'b0, '0);
`else
      run("raw_st1", s, 1'b1, '0);
      s.xm_we = 1'b1; s.xm_rd = 2'd1; s.xm_res = 16'h0021;
      run("raw_st2", s, 1'b1, '0);
      s = rtype(ALU_ADD, 2'd1, 2'd1, 2'd2, 16'h0001, 16'h0001);
      s.wb_we = 1'b1; s.wb_rd = 2'd1; s.wb_res = 16'h0021;
      run("raw_release", s, 1'b0, exi(ALU_ADD, 16'h0021, 16'h0021, 16'h0021, 2'd2, 1'b0));
      run("raw_add", nop(), 1'b0, '0);
`endif
      run("drain", nop(), 1'b0, '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 16-bit simplified MIPS datapath, sitting directly upstream of the ALU. It registers the decoded instruction, including operands, immediate, destination and control bits. It drives the ALU `a`, `b` and `op` inputs through an operand-forwarding network fed from the EX/MEM and MEM/WB stages. It also detects load-use and RAW hazards, stalling the ID stage and inserting bubbles into EX.

## Interface
- `WIDTH`, 16: datapath width.
- `REG_AW`, 2: register index width (4 registers; r0 reads as zero and is never a forwarding source).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rs_data`, `id_rt_data` in WIDTH: register-file read data.
- `id_imm` in WIDTH: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in REG_AW: register indices.
- `id_alu_op` in 4: {ainvert, binvert, sel[1:0]}.
- `id_alusrc`, `id_regdst`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`, `id_branch` in 1: decoded controls.
- `flush` in 1: taken branch; squash the ID instruction.
- `exmem_regwrite` in 1, `exmem_rd` in REG_AW, `exmem_result` in WIDTH: EX/MEM forwarding source.
- `memwb_regwrite` in 1, `memwb_rd` in REG_AW, `memwb_result` in WIDTH: MEM/WB forwarding and write-back source.
- `stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid` out 1; `ex_alu_op` out 4; `ex_a`, `ex_b`, `ex_store_data` out WIDTH; `ex_wreg` out REG_AW.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg`, `ex_branch` out 1.

## Operation
- **Capture:** `ex_wreg` = `id_regdst` ? `id_rd` : `id_rt`.
- **Write-back bypass at capture** (always built): if `memwb_regwrite` and `memwb_rd`==`id_rs`≠0, the registered rs value is `memwb_result`. The same rule applies to rt.
- **Operand use:** `uses_rt` = !`id_alusrc` | `id_memwrite` | `id_branch`. `id_rs` is always used when `id_valid`.
- **Load-use hazard:** `ex_valid` & `ex_memread` & `ex_wreg`≠0 & (`ex_wreg`==`id_rs` | (`uses_rt` & `ex_wreg`==`id_rt`)).
- **`stall`** = `id_valid` & hazard & !`flush`. It is combinational.
- **Next-state priority:** reset > flush > stall > load.
  - reset, flush or stall: load a bubble (all `ex_*` control bits 0, `ex_valid`=0, data registers 0).
  - otherwise: load the ID fields, with `ex_valid`=`id_valid`. If `id_valid`=0, the control bits load as 0.
- **Forwarding** (combinational on registered operands):
  - Source rs: the EX/MEM match (`exmem_regwrite`, `exmem_rd`≠0, `exmem_rd`==rs) wins.
  - Otherwise the MEM/WB match wins.
  - Otherwise the registered value is used.
  - rt is forwarded by the same rule.
- **Outputs:** `ex_a` = fwd(rs); `ex_store_data` = fwd(rt); `ex_b` = `ex_alusrc` ? registered imm : fwd(rt).
- **`ex_alu_op`** passes through unchanged. Encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.

## Timing
- ID→EX latency is 1 cycle.
- `ex_a`/`ex_b` settle combinationally in the same cycle as the EX/MEM and MEM/WB inputs.
- Reset values: all `ex_*` outputs 0; `stall` follows from `ex_valid`=0, so `stall`=0.
- Load-use with forwarding: exactly 1 bubble. On the following cycle the load has moved to EX/MEM; it is resolved from `memwb_*` only once its data is available.
- `flush` together with a hazard: bubble, `stall`=0.
- Reset asserted mid-stall: bubble and `stall`=0 next cycle.

## Configuration
- **`ID_EX_FORWARD_EN` defined:** forwarding network as above; only load-use stalls.
- **`ID_EX_FORWARD_EN` undefined:**
  - `ex_a` = registered rs; `ex_b`/`ex_store_data` use the registered rt or imm (no forwarding muxes).
  - The hazard term becomes any RAW against the EX stage (`ex_valid` & `ex_regwrite`) or the EX/MEM stage (`exmem_regwrite`), for a nonzero matching index.
  - Up to 2 bubbles per dependency.
  - The write-back bypass at capture remains.

## Structure
- **Shared package `mips_pkg`:** `WIDTH`, `REG_AW`, the ALU op constants (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`), and the control-bit bundle layout.
- **Sub-module `fwd_mux`:** one-operand forwarding select (index, registered data, two source tuples → data). Instantiated for rs and rt.

## Test plan
- **Reset.** Stimulus: hold `reset` 2 cycles with `id_valid`=1. Required: all `ex_*`=0, `stall`=0.
- **EX/MEM forward.** Stimulus: `add r1,r2,r3` with registered rs=5 and `exmem_regwrite`=1, `exmem_rd`=2, `exmem_result`=0x1234. Required: `ex_a`=0x1234, `ex_alu_op`=0010.
- **Dual match priority.** Stimulus: rs=1 matches both sources, `exmem_result`=0x00AA, `memwb_result`=0x00BB. Required: `ex_a`=0x00AA. The same case with rd=0 on both sources gives `ex_a`=the registered value.
- **Load-use.** Stimulus: `lw r2` in EX, `sub r3,r2,r1` in ID. Required: `stall`=1 for exactly 1 cycle, one bubble with `ex_valid`=0, then `sub` enters with `ex_alu_op`=0110.
- **Flush.** Stimulus: `flush`=1 during a load-use hazard. Required: `stall`=0, bubble loaded.
- **Without `ID_EX_FORWARD_EN`.** Stimulus: `addi r1`, followed immediately by `add r2,r1,r1`. Required: `stall`=1 for 2 cycles, `ex_a`=the write-back-bypassed value of r1.
